wb_stage: RTL and testbench



---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_stage_load_align.sv | 36 +++
 rtl/wb_stage.sv | 91 +++++++++
 tb/tb_wb_stage.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: writeback source select and load funct3 types.
package wb_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'd0,
        WB_SEL_MEM = 2'd1,
        WB_SEL_PC4 = 2'd2,
        WB_SEL_RSV = 2'd3
    } wb_sel_e;

    typedef enum logic [2:0] {
        LD_LB  = 3'd0,
        LD_LH  = 3'd1,
        LD_LW  = 3'd2,
        LD_LBU = 3'd4,
        LD_LHU = 3'd5
    } ld_type_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data extraction/extension and misalignment detection (combinational).
module load_align
    import wb_pkg::*;
(
    input  logic [2:0]      ld_type,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] mem_data,
    output logic [XLEN-1:0] ld_data,
    output logic            misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(mem_data >> {addr_lo, 3'b000});
        half_sel = 16'(mem_data >> {addr_lo[1], 4'b0000});
        ld_data  = mem_data;
        misalign = 1'b0;
        case (ld_type_e'(ld_type))
            LD_LB:  ld_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LD_LBU: ld_data = {{(XLEN-8){1'b0}}, byte_sel};
            LD_LH: begin
                ld_data  = {{(XLEN-16){half_sel[15]}}, half_sel};
                misalign = addr_lo[0];
            end
            LD_LHU: begin
                ld_data  = {{(XLEN-16){1'b0}}, half_sel};
                misalign = addr_lo[0];
            end
            // LW and the undefined encodings pass the full word
            default: misalign = (addr_lo != 2'b00);
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers MEM results, drives the register-file write port and
// same-cycle forwarding copy, and counts retired instructions.
module wb_stage
    import wb_pkg::*;
#(
    parameter int unsigned XLEN_P = XLEN,
    parameter int unsigned CNT_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic              rd_wen_i,
    input  logic [4:0]        rd_addr_i,
    input  logic [1:0]        wb_sel_i,
    input  logic [XLEN_P-1:0] alu_res_i,
    input  logic [XLEN_P-1:0] mem_data_i,
    input  logic [XLEN_P-1:0] pc_plus4_i,
    input  logic [2:0]        ld_type_i,
    input  logic [1:0]        addr_lo_i,
    output logic              w_en_o,
    output logic [XLEN_P-1:0] w_addr_o,
    output logic [XLEN_P-1:0] w_data_o,
    output logic              fwd_valid_o,
    output logic [4:0]        fwd_addr_o,
    output logic [XLEN_P-1:0] fwd_data_o,
    output logic              misalign_o,
    output logic [CNT_W-1:0]  instret_o
);

    logic [XLEN_P-1:0] ld_data;
    logic              ld_misalign;
    logic              valid_d;
    logic              misalign_d;
    logic              wen_d;
    logic [XLEN_P-1:0] sel_data;

    logic              w_en_q;
    logic [4:0]        rd_q;
    logic [XLEN_P-1:0] w_data_q;
    logic              misalign_q;
    logic [CNT_W-1:0]  instret_q;

    load_align u_load_align (
        .ld_type  (ld_type_i),
        .addr_lo  (addr_lo_i),
        .mem_data (mem_data_i),
        .ld_data  (ld_data),
        .misalign (ld_misalign)
    );

    // Decisions are made before the edge so every output comes straight from a flop.
    always_comb begin
        valid_d    = valid_i & ~flush_i;
        misalign_d = valid_d & (wb_sel_i == WB_SEL_MEM) & ld_misalign;
        wen_d      = valid_d & rd_wen_i & (rd_addr_i != 5'd0) & ~misalign_d;
        sel_data   = alu_res_i;
        case (wb_sel_e'(wb_sel_i))
            WB_SEL_MEM: sel_data = ld_data;
            WB_SEL_PC4: sel_data = pc_plus4_i;
            default:    sel_data = alu_res_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_en_q     <= 1'b0;
            rd_q       <= '0;
            w_data_q   <= '0;
            misalign_q <= 1'b0;
            instret_q  <= '0;
        end else begin
            w_en_q     <= wen_d;
            rd_q       <= rd_addr_i;
            w_data_q   <= valid_d ? sel_data : '0;
            misalign_q <= misalign_d;
            if (valid_d && !misalign_d)
                instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign w_en_o      = w_en_q;
    assign w_addr_o    = {{(XLEN_P-5){1'b0}}, rd_q};
    assign w_data_o    = w_data_q;
    assign fwd_valid_o = w_en_q;
    assign fwd_addr_o  = rd_q;
    assign fwd_data_o  = w_data_q;
    assign misalign_o  = misalign_q;
    assign instret_o   = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage; a second instance with a 4-bit counter checks wrap.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i, flush_i, rd_wen_i;
    logic [4:0]  rd_addr_i;
    logic [1:0]  wb_sel_i;
    logic [31:0] alu_res_i, mem_data_i, pc_plus4_i;
    logic [2:0]  ld_type_i;
    logic [1:0]  addr_lo_i;

    logic        w_en_o, fwd_valid_o, misalign_o;
    logic [31:0] w_addr_o, w_data_o, fwd_data_o;
    logic [4:0]  fwd_addr_o;
    logic [63:0] instret_o;

    logic        n_w_en, n_fwd_valid, n_misalign;
    logic [31:0] n_w_addr, n_w_data, n_fwd_data;
    logic [4:0]  n_fwd_addr;
    logic [3:0]  n_instret;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .flush_i(flush_i),
        .rd_wen_i(rd_wen_i), .rd_addr_i(rd_addr_i), .wb_sel_i(wb_sel_i),
        .alu_res_i(alu_res_i), .mem_data_i(mem_data_i), .pc_plus4_i(pc_plus4_i),
        .ld_type_i(ld_type_i), .addr_lo_i(addr_lo_i),
        .w_en_o(w_en_o), .w_addr_o(w_addr_o), .w_data_o(w_data_o),
        .fwd_valid_o(fwd_valid_o), .fwd_addr_o(fwd_addr_o), .fwd_data_o(fwd_data_o),
        .misalign_o(misalign_o), .instret_o(instret_o)
    );

    wb_stage #(.CNT_W(4)) dut_w (
        .clk(clk), .reset(reset), .valid_i(valid_i), .flush_i(flush_i),
        .rd_wen_i(rd_wen_i), .rd_addr_i(rd_addr_i), .wb_sel_i(wb_sel_i),
        .alu_res_i(alu_res_i), .mem_data_i(mem_data_i), .pc_plus4_i(pc_plus4_i),
        .ld_type_i(ld_type_i), .addr_lo_i(addr_lo_i),
        .w_en_o(n_w_en), .w_addr_o(n_w_addr), .w_data_o(n_w_data),
        .fwd_valid_o(n_fwd_valid), .fwd_addr_o(n_fwd_addr), .fwd_data_o(n_fwd_data),
        .misalign_o(n_misalign), .instret_o(n_instret)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one instruction slot, clock it in, then settle just after the edge.
    task automatic issue(input logic v, input logic fl, input logic wen, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pc4, input logic [2:0] ld, input logic [1:0] lo);
        valid_i = v; flush_i = fl; rd_wen_i = wen; rd_addr_i = rd; wb_sel_i = sel;
        alu_res_i = alu; mem_data_i = mem; pc_plus4_i = pc4; ld_type_i = ld; addr_lo_i = lo;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] ld, input logic [1:0] lo, input logic [31:0] exp,
                        input logic [63:0] cnt, input string tag);
        issue(1, 0, 1, 5'd9, 2'd1, 32'h1111_1111, 32'h80FF_7F01, 32'h0, ld, lo);
        check({tag, "_wen"}, w_en_o, 1);
        check({tag, "_data"}, w_data_o, exp);
        check({tag, "_cnt"}, instret_o, cnt);
    endtask

    initial begin
        reset = 1'b1;
        issue(0, 0, 0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0);
        issue(0, 0, 0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0);
        check("rst_wen", w_en_o, 0);
        check("rst_fwdv", fwd_valid_o, 0);
        check("rst_data", w_data_o, 0);
        check("rst_mis", misalign_o, 0);
        check("rst_cnt", instret_o, 0);
        reset = 1'b0;

        issue(1, 0, 1, 5'd5, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 3'd2, 2'd0);
        check("alu_wen", w_en_o, 1);
        check("alu_addr", w_addr_o, 5);
        check("alu_data", w_data_o, 32'hDEAD_BEEF);
        check("alu_fwda", fwd_addr_o, 5);
        check("alu_cnt", instret_o, 1);

        load(3'd0, 2'd1, 32'h0000_007F, 2, "lb1");
        load(3'd0, 2'd2, 32'hFFFF_FFFF, 3, "lb2");
        load(3'd4, 2'd3, 32'h0000_0080, 4, "lbu3");
        load(3'd1, 2'd2, 32'hFFFF_80FF, 5, "lh2");
        load(3'd5, 2'd0, 32'h0000_7F01, 6, "lhu0");
        load(3'd2, 2'd0, 32'h80FF_7F01, 7, "lw0");
        load(3'd6, 2'd0, 32'h80FF_7F01, 8, "ld6");

        issue(1, 0, 1, 5'd3, 2'd1, 32'h0, 32'h80FF_7F01, 32'h0, 3'd2, 2'd2);
        check("lwmis_wen", w_en_o, 0);
        check("lwmis_pulse", misalign_o, 1);
        check("lwmis_cnt", instret_o, 8);
        issue(0, 0, 0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0);
        check("lwmis_pulse_end", misalign_o, 0);
        check("lwmis_cnt2", instret_o, 8);
        issue(1, 0, 1, 5'd3, 2'd1, 32'h0, 32'h80FF_7F01, 32'h0, 3'd5, 2'd1);
        check("lhumis_pulse", misalign_o, 1);
        check("lhumis_wen", w_en_o, 0);
        issue(1, 0, 1, 5'd3, 2'd0, 32'h0, 32'h80FF_7F01, 32'h0, 3'd2, 2'd2);
        check("alu_lo_nomis", misalign_o, 0);
        check("alu_lo_wen", w_en_o, 1);
        check("alu_lo_cnt", instret_o, 9);

        issue(1, 0, 1, 5'd0, 2'd0, 32'h1234_5678, 32'h0, 32'h0, 3'd2, 2'd0);
        check("x0_wen", w_en_o, 0);
        check("x0_cnt", instret_o, 10);
        issue(1, 0, 0, 5'd4, 2'd0, 32'h0BAD_F00D, 32'h0, 32'h0, 3'd2, 2'd0);
        check("nowen_wen", w_en_o, 0);
        check("nowen_data", w_data_o, 32'h0BAD_F00D);
        check("nowen_cnt", instret_o, 11);
        issue(1, 1, 1, 5'd6, 2'd0, 32'hCAFE_0000, 32'h0, 32'h0, 3'd2, 2'd0);
        check("flush_wen", w_en_o, 0);
        check("flush_data", w_data_o, 0);
        check("flush_cnt", instret_o, 11);
        issue(1, 0, 1, 5'd8, 2'd3, 32'hA5A5_5A5A, 32'h1, 32'h2, 3'd2, 2'd0);
        check("sel3_data", w_data_o, 32'hA5A5_5A5A);
        check("sel3_cnt", instret_o, 12);

        reset = 1'b1;
        issue(1, 0, 1, 5'd7, 2'd0, 32'h7777_7777, 32'h0, 32'h0, 3'd2, 2'd0);
        check("rstv_wen", w_en_o, 0);
        check("rstv_data", w_data_o, 0);
        check("rstv_cnt", instret_o, 0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            issue(1, 0, 1, 5'd1, 2'd2, 32'h0, 32'h0, 32'h0000_0104, 3'd2, 2'd0);
            check("pc4_wen", w_en_o, 1);
            check("pc4_data", w_data_o, 32'h0000_0104);
            check("pc4_fwdv", fwd_valid_o, 1);
            check("pc4_fwda", fwd_addr_o, 1);
            check("pc4_fwdd", fwd_data_o, 32'h0000_0104);
        end
        check("pc4_cnt", instret_o, 4);
        check("narrow_cnt4", n_instret, 4);

        for (int i = 0; i < 11; i++)
            issue(1, 0, 1, 5'd2, 2'd0, 32'h0, 32'h0, 32'h0, 3'd2, 2'd0);
        check("narrow_max", n_instret, 4'hF);
        issue(1, 0, 1, 5'd2, 2'd0, 32'h0, 32'h0, 32'h0, 3'd2, 2'd0);
        check("narrow_wrap", n_instret, 0);
        check("wide_nowrap", instret_o, 16);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
